multi_ch_pattern_out: RTL
=========================

# multi_ch_pattern_out

Parametrised multi-channel successor to the fixed 3-channel, 32-bit differential-frequency serial output block. Sits behind the UART receiver: collects a packet of bytes (output pattern, per-bit speed pattern, control byte) and drives one of `CH_NUM` serial outputs. Each bit is held for a low-speed or high-speed period selected per bit. Adds a programmable idle level, a stop command, reload-while-busy, an inter-byte timeout and command-error reporting.

## Interface
- `DATA_BIT`, 32, pattern width in bits; multiple of 8, range 8..64
- `CH_NUM`, 3, number of serial channels; range 1..16
- `LOW_DIV`, 1000, clocks per bit when speed bit = 0; ≥ 2
- `HIGH_DIV`, 100, clocks per bit when speed bit = 1; ≥ 2
- `TIMEOUT_CLK`, 100000, idle clocks between bytes before a partial packet is discarded
- `clk`  in  1  system clock
- `rst_n`  in  1  reset rst_n, asynchronous, active-high
- `i_data`  in  8  received UART byte
- `i_rx_done_tick`  in  1  one-cycle strobe; `i_data` is valid in the same cycle
- `o_serial_out`  out  CH_NUM  serial outputs
- `o_bit_tick`  out  CH_NUM  one-cycle pulse on the last clock of each bit
- `o_done_tick`  out  CH_NUM  one-cycle pulse when a pattern pass completes
- `o_busy`  out  CH_NUM  channel is currently shifting
- `o_cmd_err`  out  1  one-cycle pulse when a control byte is rejected

## Operation
- Packet length: `PACK_NUM = 2*DATA_BIT/8 + 1` bytes.
  - Bytes 0..DATA_BIT/8-1 form the output pattern, least-significant byte first.
  - The next DATA_BIT/8 bytes form the speed pattern, same byte order.
  - The final byte is control.
- Control byte fields:
  - [7:4] channel index
  - [3] idle level
  - [2] mode: 0 = one-shot, 1 = repeat
  - [1:0] command: 01 = load & start, 10 = stop, 00 and 11 = reserved
- Packer: a byte counter runs 0..PACK_NUM-1 and increments on each `i_rx_done_tick`. It wraps to 0 after the control byte.
- Timeout: a gap counter clears on every byte. If it reaches `TIMEOUT_CLK` while the byte counter ≠ 0, the byte counter returns to 0 and the partial packet is dropped silently.
- Control-byte rejection: if the channel index ≥ `CH_NUM` or the command is reserved, the packet is discarded, `o_cmd_err` pulses, and no channel changes state.
- Channel FSM, states `IDLE` and `SHIFT`:
  - `IDLE`: output = stored idle level.
  - Load in `IDLE` or `SHIFT`: latch both patterns, idle level and mode; set bit index = 0 and divider = 0; go to `SHIFT`. Reload while busy aborts the current pass with no done tick.
  - `SHIFT`: output = `pattern[idx]`, where idx = 0 (LSB) is sent first. The bit lasts `HIGH_DIV` clocks if `speed[idx]` = 1, otherwise `LOW_DIV` clocks.
  - End of bit: `o_bit_tick` pulses on that bit's last clock, then idx increments.
  - After bit DATA_BIT-1: `o_done_tick` pulses together with the final `o_bit_tick`. One-shot goes to `IDLE`. Repeat wraps to idx 0 with no gap clock.
  - Stop command: go to `IDLE` on the next clock with no done tick. A stop to an idle channel only updates its idle level.
- Divider width: `$clog2(max(LOW_DIV,HIGH_DIV))`. Bit-index width: `$clog2(DATA_BIT)`.

## Timing
- Reset (rst_n = 1), asynchronous:
  - `o_serial_out` = 0, all ticks = 0, `o_busy` = 0, `o_cmd_err` = 0
  - stored idle levels = 0; byte and gap counters = 0; all channels `IDLE`
- Control byte strobe at cycle N:
  - cycle N+1: decode is registered; load/stop strobe goes to the channel and `o_cmd_err` is asserted if the byte is rejected
  - cycle N+2: `o_busy` = 1 and `o_serial_out` = pattern bit 0
- Bit k occupies exactly `DIV(speed[k])` consecutive clocks.
- One-shot pass length = Σ DIV(speed[k]) clocks. The idle level appears on the clock after `o_done_tick`.
- Simultaneous timeout and byte strobe: the byte wins and is counted as the next byte.
- Channels run independently. Any number may shift at the same time.

## Structure
- Package `pattern_out_pkg`:
  - command encodings `CMD_LOAD`, `CMD_STOP`
  - control field bit offsets
  - mode constants `ONE_SHOT`, `REPEAT`
  - function `pack_num(data_bit)`
- Sub-module `pattern_channel`: per-channel FSM, divider and bit index. The top level generates `CH_NUM` instances plus the shared packer/decoder.

## Test plan
- DATA_BIT=32, LOW_DIV=8, HIGH_DIV=2:
  - Load ch0 one-shot with pattern 0x00FF00FF, speed 0, idle 0 → 8 high bits then 8 low bits, repeating, 8 clocks each.
  - The pass lasts 256 clocks, 32 bit ticks occur, one done tick, then output returns to 0.
- Load ch1 repeat with speed 0x0000FFFF and idle 1:
  - bits 0..15 are 2 clocks each, bits 16..31 are 8 clocks each
  - `o_done_tick` every 160 clocks with no gap
  - after a stop command: output = 1 and busy = 0 at N+2
- Send 5 bytes, idle for `TIMEOUT_CLK`, then send a full 9-byte packet → only the new packet takes effect.
- Control byte with channel index 5 (CH_NUM=3) or command 11 → `o_cmd_err` pulse, all outputs unchanged.
- Reload ch2 while it is mid-pass → no done tick; new pattern bit 0 at N+2.
- Assert rst_n = 1 mid-shift → all outputs return to 0 immediately, asynchronously.

Source files
------------

// File: rtl/pattern_out_pkg.sv
// Shared constants for the multi-channel pattern output block: control byte
// layout, command and mode encodings, channel FSM states, packet length helper.
package pattern_out_pkg;

  localparam logic [1:0] CMD_LOAD = 2'b01;
  localparam logic [1:0] CMD_STOP = 2'b10;

  // Control byte layout: {channel[3:0], idle, mode, cmd[1:0]}
  localparam int unsigned CTRL_CH_LSB   = 4;
  localparam int unsigned CTRL_CH_W     = 4;
  localparam int unsigned CTRL_IDLE_BIT = 3;
  localparam int unsigned CTRL_MODE_BIT = 2;
  localparam int unsigned CTRL_CMD_LSB  = 0;
  localparam int unsigned CTRL_CMD_W    = 2;

  localparam logic ONE_SHOT = 1'b0;
  localparam logic REPEAT   = 1'b1;

  typedef enum logic {StIdle, StShift} ch_state_e;

  // Bytes per packet: output pattern, speed pattern, control byte.
  function automatic int unsigned pack_num(input int unsigned data_bit);
    return 2 * data_bit / 8 + 1;
  endfunction

endpackage

// File: rtl/multi_ch_pattern_out_if.sv
// Byte input and per-channel serial outputs of the pattern output block.
interface multi_ch_pattern_out_if #(
  parameter int unsigned CH_NUM = 3
);
  logic [7:0]        i_data;
  logic              i_rx_done_tick;
  logic [CH_NUM-1:0] o_serial_out;
  logic [CH_NUM-1:0] o_bit_tick;
  logic [CH_NUM-1:0] o_done_tick;
  logic [CH_NUM-1:0] o_busy;
  logic              o_cmd_err;

  modport master (
    output i_data, i_rx_done_tick,
    input  o_serial_out, o_bit_tick, o_done_tick, o_busy, o_cmd_err
  );

  modport slave (
    input  i_data, i_rx_done_tick,
    output o_serial_out, o_bit_tick, o_done_tick, o_busy, o_cmd_err
  );
endinterface

// File: rtl/pattern_channel.sv
// One serial channel: holds a pattern and per-bit speed, shifts LSB first with
// each bit held for LOW_DIV or HIGH_DIV clocks, one-shot or repeating.
module pattern_channel
  import pattern_out_pkg::*;
#(
  parameter int unsigned DATA_BIT = 32,
  parameter int unsigned LOW_DIV  = 1000,
  parameter int unsigned HIGH_DIV = 100
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load_i,
  input  logic                stop_i,
  input  logic [DATA_BIT-1:0] pat_i,
  input  logic [DATA_BIT-1:0] spd_i,
  input  logic                idle_i,
  input  logic                mode_i,
  output logic                serial_o,
  output logic                bit_tick_o,
  output logic                done_tick_o,
  output logic                busy_o
);

  localparam int unsigned MaxDiv = (LOW_DIV > HIGH_DIV) ? LOW_DIV : HIGH_DIV;
  localparam int unsigned DivW   = $clog2(MaxDiv);
  localparam int unsigned IdxW   = $clog2(DATA_BIT);

  ch_state_e           state_q, state_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [DivW-1:0]     div_q, div_d;
  logic [DATA_BIT-1:0] pat_q, pat_d;
  logic [DATA_BIT-1:0] spd_q, spd_d;
  logic                idle_q, idle_d;
  logic                mode_q, mode_d;

  logic [DivW-1:0] div_last;
  logic            bit_end;
  logic            last_bit;
  logic            shifting;

  // State register; reset is asynchronous and asserted high.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      div_q   <= '0;
      pat_q   <= '0;
      spd_q   <= '0;
      idle_q  <= 1'b0;
      mode_q  <= ONE_SHOT;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      div_q   <= div_d;
      pat_q   <= pat_d;
      spd_q   <= spd_d;
      idle_q  <= idle_d;
      mode_q  <= mode_d;
    end
  end

  // Next state, divider/index stepping and outputs.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    div_d    = div_q;
    pat_d    = pat_q;
    spd_d    = spd_q;
    idle_d   = idle_q;
    mode_d   = mode_q;

    shifting = (state_q == StShift);
    div_last = spd_q[idx_q] ? DivW'(HIGH_DIV - 1) : DivW'(LOW_DIV - 1);
    bit_end  = shifting && (div_q == div_last);
    last_bit = (idx_q == IdxW'(DATA_BIT - 1));

    if (load_i) begin
      // Reload aborts any pass in flight.
      pat_d   = pat_i;
      spd_d   = spd_i;
      idle_d  = idle_i;
      mode_d  = mode_i;
      idx_d   = '0;
      div_d   = '0;
      state_d = StShift;
    end else if (stop_i) begin
      idle_d  = idle_i;
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle: ;
        StShift: begin
          if (bit_end) begin
            div_d = '0;
            if (last_bit) begin
              idx_d = '0;
              if (mode_q != REPEAT) state_d = StIdle;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            div_d = div_q + 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    busy_o      = shifting;
    serial_o    = shifting ? pat_q[idx_q] : idle_q;
    // An incoming load/stop cancels the pass, so its last bit never completes.
    bit_tick_o  = bit_end && !load_i && !stop_i;
    done_tick_o = bit_end && !load_i && !stop_i && last_bit;
  end

endmodule

// File: rtl/multi_ch_pattern_out.sv
// Multi-channel pattern output: packs UART bytes into a pattern/speed/control
// packet, decodes the control byte and strobes one of CH_NUM channels.
module multi_ch_pattern_out
  import pattern_out_pkg::*;
#(
  parameter int unsigned DATA_BIT    = 32,
  parameter int unsigned CH_NUM      = 3,
  parameter int unsigned LOW_DIV     = 1000,
  parameter int unsigned HIGH_DIV    = 100,
  parameter int unsigned TIMEOUT_CLK = 100000
) (
  input logic                    clk,
  input logic                    rst_n,
  multi_ch_pattern_out_if.slave  bus
);

  localparam int unsigned PACK_NUM = pack_num(DATA_BIT);
  localparam int unsigned NB       = DATA_BIT / 8;
  localparam int unsigned CW       = $clog2(PACK_NUM);
  localparam int unsigned GW       = $clog2(TIMEOUT_CLK + 1);

  logic [CW-1:0]       cnt_q, cnt_d;
  logic [GW-1:0]       gap_q, gap_d;
  logic [DATA_BIT-1:0] pat_buf_q, pat_buf_d;
  logic [DATA_BIT-1:0] spd_buf_q, spd_buf_d;
  logic                ctrl_valid;

  logic [CTRL_CH_W-1:0]  ch_idx;
  logic [CTRL_CMD_W-1:0] cmd;
  logic                  ch_ok, cmd_ok;
  logic [CH_NUM-1:0]     load_q, load_d;
  logic [CH_NUM-1:0]     stop_q, stop_d;
  logic                  ctl_idle_q, ctl_idle_d;
  logic                  ctl_mode_q, ctl_mode_d;
  logic                  cmd_err_q, cmd_err_d;

  logic [CH_NUM-1:0] serial, bit_tick, done_tick, busy;

  // Packer and decode registers.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      cnt_q      <= '0;
      gap_q      <= '0;
      pat_buf_q  <= '0;
      spd_buf_q  <= '0;
      load_q     <= '0;
      stop_q     <= '0;
      ctl_idle_q <= 1'b0;
      ctl_mode_q <= ONE_SHOT;
      cmd_err_q  <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      gap_q      <= gap_d;
      pat_buf_q  <= pat_buf_d;
      spd_buf_q  <= spd_buf_d;
      load_q     <= load_d;
      stop_q     <= stop_d;
      ctl_idle_q <= ctl_idle_d;
      ctl_mode_q <= ctl_mode_d;
      cmd_err_q  <= cmd_err_d;
    end
  end

  // Byte counter, inter-byte timeout and pattern/speed byte capture.
  always_comb begin
    cnt_d      = cnt_q;
    gap_d      = gap_q;
    pat_buf_d  = pat_buf_q;
    spd_buf_d  = spd_buf_q;
    ctrl_valid = 1'b0;
    if (bus.i_rx_done_tick) begin
      // A byte always wins over a coincident timeout.
      gap_d = '0;
      if (cnt_q == CW'(PACK_NUM - 1)) begin
        cnt_d      = '0;
        ctrl_valid = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      for (int b = 0; b < NB; b++) begin
        if (cnt_q == CW'(b))      pat_buf_d[b*8 +: 8] = bus.i_data;
        if (cnt_q == CW'(NB + b)) spd_buf_d[b*8 +: 8] = bus.i_data;
      end
    end else if (gap_q != GW'(TIMEOUT_CLK)) begin
      gap_d = gap_q + 1'b1;
    end else if (cnt_q != '0) begin
      cnt_d = '0;
    end
  end

  // Control byte decode into per-channel load/stop strobes or an error pulse.
  always_comb begin
    ch_idx     = bus.i_data[CTRL_CH_LSB +: CTRL_CH_W];
    cmd        = bus.i_data[CTRL_CMD_LSB +: CTRL_CMD_W];
    ch_ok      = (32'(ch_idx) < CH_NUM);
    cmd_ok     = (cmd == CMD_LOAD) || (cmd == CMD_STOP);
    cmd_err_d  = ctrl_valid && !(ch_ok && cmd_ok);
    ctl_idle_d = ctl_idle_q;
    ctl_mode_d = ctl_mode_q;
    if (ctrl_valid) begin
      ctl_idle_d = bus.i_data[CTRL_IDLE_BIT];
      ctl_mode_d = bus.i_data[CTRL_MODE_BIT];
    end
    for (int i = 0; i < CH_NUM; i++) begin
      load_d[i] = ctrl_valid && (cmd == CMD_LOAD) && (ch_idx == CTRL_CH_W'(i));
      stop_d[i] = ctrl_valid && (cmd == CMD_STOP) && (ch_idx == CTRL_CH_W'(i));
    end
  end

  for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
    pattern_channel #(
      .DATA_BIT (DATA_BIT),
      .LOW_DIV  (LOW_DIV),
      .HIGH_DIV (HIGH_DIV)
    ) u_ch (
      .clk         (clk),
      .rst_n       (rst_n),
      .load_i      (load_q[g]),
      .stop_i      (stop_q[g]),
      .pat_i       (pat_buf_q),
      .spd_i       (spd_buf_q),
      .idle_i      (ctl_idle_q),
      .mode_i      (ctl_mode_q),
      .serial_o    (serial[g]),
      .bit_tick_o  (bit_tick[g]),
      .done_tick_o (done_tick[g]),
      .busy_o      (busy[g])
    );
  end

  assign bus.o_serial_out = serial;
  assign bus.o_bit_tick   = bit_tick;
  assign bus.o_done_tick  = done_tick;
  assign bus.o_busy       = busy;
  assign bus.o_cmd_err    = cmd_err_q;

endmodule
